// File: rtl/modulo_entrada_if.sv
// Bundle of the input-instruction signals shared by the control unit side
// and the input module.
//   estagioEntradaUC     : request level from the control unit
//   botaoConfirma        : raw confirm pushbutton (active-low, async)
//   switches             : raw board switch value
//   dadoEntrada          : captured switch value, zero-extended to 32 bits
//   estagioEntradaSwitch : captured data valid for the current request
//   estagioEntradaBanco  : single-cycle register-bank write strobe
//   esperandoEntrada     : "waiting for input" indicator
interface modulo_entrada_if;
    logic        estagioEntradaUC;
    logic        botaoConfirma;
    logic [15:0] switches;
    logic [31:0] dadoEntrada;
    logic        estagioEntradaSwitch;
    logic        estagioEntradaBanco;
    logic        esperandoEntrada;

    modport master (
        output estagioEntradaUC,
        output botaoConfirma,
        output switches,
        input  dadoEntrada,
        input  estagioEntradaSwitch,
        input  estagioEntradaBanco,
        input  esperandoEntrada
    );

    modport slave (
        input  estagioEntradaUC,
        input  botaoConfirma,
        input  switches,
        output dadoEntrada,
        output estagioEntradaSwitch,
        output estagioEntradaBanco,
        output esperandoEntrada
    );
endinterface

// File: rtl/modulo_entrada.sv
// Debounced user-input capture for the input instruction. While the control
// unit requests input, waits for a debounced press of the confirm button,
// captures the switches, emits one register-bank write strobe, then waits
// for a debounced release before accepting another request.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : modulo_entrada_if slave (request, button, switches, outputs)
//
// state   | meaning
// OCIOSO  | idle, no request
// ESPERA  | request active, waiting for a press
// FILTRO  | press seen, counting stable pressed cycles
// CAPTURA | switches latched, data valid
// ESCRITA | register-bank write strobe
// SOLTA   | counting stable released cycles before re-arming
module modulo_entrada #(
    parameter logic [15:0] DEBOUNCE_CICLOS = 16'd50000
) (
    input  logic             clock,
    input  logic             reset,
    modulo_entrada_if.slave  bus
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        ESPERA  = 3'd1,
        FILTRO  = 3'd2,
        CAPTURA = 3'd3,
        ESCRITA = 3'd4,
        SOLTA   = 3'd5
    } estado_t;

    localparam logic [15:0] LIMITE = DEBOUNCE_CICLOS - 16'd1;

    estado_t     estado, prox;
    logic [15:0] cnt, cnt_prox;
    logic        btn_s1, btn_s2;
    logic [15:0] sw_s1, sw_s2;
    logic        pressed;
    logic [31:0] dado_q;
    logic        switch_q, banco_q, esp_q;

    // Button resets to "released" (1) so a reset never looks like a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= bus.botaoConfirma;
            btn_s2 <= btn_s1;
            sw_s1  <= bus.switches;
            sw_s2  <= sw_s1;
        end
    end

    assign pressed = ~btn_s2;

    // Outputs are decoded from the next state so they are plain flops that
    // line up with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            cnt      <= '0;
            dado_q   <= '0;
            switch_q <= 1'b0;
            banco_q  <= 1'b0;
            esp_q    <= 1'b0;
        end else begin
            estado   <= prox;
            cnt      <= cnt_prox;
            if (prox == CAPTURA) begin
                dado_q <= {16'h0000, sw_s2};
            end
            switch_q <= (prox == CAPTURA) || (prox == ESCRITA);
            banco_q  <= (prox == ESCRITA);
            esp_q    <= (prox == ESPERA) || (prox == FILTRO);
        end
    end

    always_comb begin
        prox     = estado;
        cnt_prox = cnt;
        case (estado)
            OCIOSO: begin
                cnt_prox = '0;
                if (bus.estagioEntradaUC) prox = ESPERA;
            end
            ESPERA: begin
                if (!bus.estagioEntradaUC) begin
                    prox = OCIOSO;
                end else if (pressed) begin
                    prox     = FILTRO;
                    cnt_prox = '0;
                end
            end
            FILTRO: begin
                if (!bus.estagioEntradaUC) begin
                    prox = OCIOSO;
                end else if (!pressed) begin
                    prox = ESPERA;
                end else if (cnt == LIMITE) begin
                    prox = CAPTURA;
                end else begin
                    cnt_prox = cnt + 16'd1;
                end
            end
            // Once captured, the write must go out even if the request drops.
            CAPTURA: prox = ESCRITA;
            ESCRITA: begin
                prox     = SOLTA;
                cnt_prox = '0;
            end
            SOLTA: begin
                if (pressed) begin
                    cnt_prox = '0;
                end else if (cnt == LIMITE) begin
                    prox = OCIOSO;
                end else begin
                    cnt_prox = cnt + 16'd1;
                end
            end
            default: begin
                prox     = OCIOSO;
                cnt_prox = '0;
            end
        endcase
    end

    assign bus.dadoEntrada          = dado_q;
    assign bus.estagioEntradaSwitch = switch_q;
    assign bus.estagioEntradaBanco  = banco_q;
    assign bus.esperandoEntrada     = esp_q;

endmodule
